pll_lock_monitor: RTL and testbench
===================================

# pll_lock_monitor

Lock-qualification stage directly upstream of the reset manager and its power-on-reset FSM. It synchronizes the raw DAQ MMCM lock, QPLL lock and QPLL error inputs to the startup clock and debounces each lock. It then presents clean `MMCM_LOCK_OK` / `QPLL_LOCK_OK` levels to the POR sequencing. It also counts loss-of-lock events and issues a rate-limited relock request so a lock drop after startup re-triggers the reset sequence.

## Interface
Parameters:
- `DEB_LEN`, 16'd1000: consecutive synchronized-high cycles required to declare lock (≥2).
- `LOSS_LEN`, 16'd8: consecutive synchronized-low cycles required to declare loss (≥2).
- `HOLDOFF`, 20'h3FFFF: cycles after a `RELOCK_REQ` pulse during which further pulses are suppressed (≥1).
- `CNT_W`, 8: loss-counter width.

Ports:
- `CLK`, in, 1: startup clock; all logic on rising edge.
- `EOS`, in, 1: asynchronous, active-low reset.
- `MMCM_LOCK`, in, 1: raw DAQ MMCM locked, asynchronous.
- `QPLL_LOCK`, in, 1: raw QPLL locked, asynchronous.
- `QPLL_ERROR`, in, 1: raw QPLL error, asynchronous.
- `CLR_CNT`, in, 1: synchronous clear of both loss counters.
- `MMCM_LOCK_OK`, out, 1: debounced MMCM lock.
- `QPLL_LOCK_OK`, out, 1: debounced QPLL lock, error-qualified.
- `ALL_LOCKED`, out, 1: registered AND of both OK flags.
- `RELOCK_REQ`, out, 1: one-cycle pulse on loss of either lock.
- `MMCM_LOSS_CNT`, out, `CNT_W`: saturating MMCM loss count.
- `QPLL_LOSS_CNT`, out, `CNT_W`: saturating QPLL loss count.

## Operation
- **Reset.** While `EOS`=0, every output and every register is 0. This includes the synchronizer flops, the debounce counters and the holdoff counter.
- **Synchronization.** Each raw input passes through a 2-flop synchronizer. The resulting synchronized signals are `s_mmcm`, `s_qpll` and `s_err`.
- **Debounce.** Each channel has one counter.
  - When the synchronized input equals OK, the counter is 0.
  - When they differ, the counter increments.
  - OK rises on the edge where the counter would reach `DEB_LEN` with input high. OK falls on the edge where it would reach `LOSS_LEN` with input low. On either change the counter returns to 0.
  - Any mismatch run shorter than the threshold leaves OK unchanged and clears the counter.
- **QPLL error.** For the QPLL channel, the effective input is `s_qpll & ~s_err`.
  - If `s_err`=1 while `QPLL_LOCK_OK`=1, the flag clears on the next edge, bypassing `LOSS_LEN`, and the counter clears.
  - Re-lock then needs `DEB_LEN` clean cycles.
- **Loss counting.** Each counter increments on its OK 1→0 transition and saturates at all-ones.
  - `CLR_CNT`=1 zeroes both counters.
  - If `CLR_CNT` and a falling edge occur in the same cycle, the result is 1.
  - A lock that is never acquired counts nothing.
- **Relock FSM.** States are `IDLE` and `HOLD`.
  - In `IDLE`, a falling edge of either OK flag pulses `RELOCK_REQ` for one cycle and moves to `HOLD` with the holdoff counter at 0.
  - Simultaneous falls of both flags give one pulse.
  - In `HOLD`, the counter increments each cycle. At `HOLDOFF-1` the FSM returns to `IDLE`.
  - Falls during `HOLD` produce no pulse but are still counted.
  - A fall coincident with the return to `IDLE` produces no pulse.
- **ALL_LOCKED.** `ALL_LOCKED` is the registered AND of both OK flags, so it lags them by one cycle.

## Timing
- MMCM assertion: with `MMCM_LOCK` steady high from edge k, `s_mmcm`=1 from edge k+2 and `MMCM_LOCK_OK`=1 from edge k+1+`DEB_LEN`.
- QPLL assertion: same as MMCM, with `QPLL_LOCK` high and `QPLL_ERROR` low.
- Loss: a steady low from edge k gives OK=0 at edge k+1+`LOSS_LEN` and `RELOCK_REQ`=1 for exactly one cycle at edge k+2+`LOSS_LEN`.
- Error path: `QPLL_ERROR` high at edge k gives `QPLL_LOCK_OK`=0 at edge k+3 and `RELOCK_REQ` at k+4.
- Counters update in the same cycle as `RELOCK_REQ`.
- Reset asserted mid-operation clears everything immediately, including an active `HOLD`. After release, OK flags re-qualify from scratch.

## Structure
- Shared package `pll_lock_monitor_pkg`: default `DEB_LEN`, `LOSS_LEN`, `HOLDOFF` constants; relock-FSM state encoding (`IDLE`=0, `HOLD`=1).
- One natural sub-module, `lock_debounce`, instantiated twice. It contains the 2-flop synchronizer, the asymmetric debounce counter, and a force-clear input (tied low for the MMCM instance, driven by `s_err` for the QPLL instance).
- The top level holds the loss counters, the relock FSM, `ALL_LOCKED` and the error synchronizer.

## Test plan
- Reset and acquire (`DEB_LEN`=10, `LOSS_LEN`=4): `EOS` low, then high; both locks high at edge 0 → OKs=1 at edge 11, `ALL_LOCKED`=1 at edge 12, counters 0, no `RELOCK_REQ`.
- Glitch filtering: after lock, drop `MMCM_LOCK` for 3 cycles → `MMCM_LOCK_OK` stays 1. Drop for 4 cycles → OK=0, one `RELOCK_REQ` pulse, `MMCM_LOSS_CNT`=1.
- QPLL error: while locked, pulse `QPLL_ERROR` for 1 cycle with `QPLL_LOCK` high → `QPLL_LOCK_OK`=0 at +3, `QPLL_LOSS_CNT`=1, re-lock 10 clean cycles later.
- Holdoff (`HOLDOFF`=50): three MMCM losses 20 cycles apart → one `RELOCK_REQ` and `MMCM_LOSS_CNT`=3. A loss 60 cycles after the first → second pulse.
- Saturation and clear (`CNT_W`=2): five QPLL losses → count 3. `CLR_CNT` coincident with a sixth loss → count 1. `CLR_CNT` alone → 0.
- Reset mid-`HOLD`: assert `EOS` low during `HOLD` → all outputs 0 immediately. After release, a loss yields a fresh `RELOCK_REQ` without waiting out the old holdoff.

Source files
------------

// File: rtl/pll_lock_monitor_pkg.sv
// Shared constants and types for the PLL lock-qualification block.
package pll_lock_monitor_pkg;

  localparam logic [15:0] DEF_DEB_LEN  = 16'd1000;
  localparam logic [15:0] DEF_LOSS_LEN = 16'd8;
  localparam logic [19:0] DEF_HOLDOFF  = 20'h3FFFF;
  localparam int          DEF_CNT_W    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } relock_state_t;

  // Mismatch-run length needed to flip a lock flag from its current value.
  function automatic logic [15:0] run_limit(input logic        ok,
                                            input logic [15:0] deb_len,
                                            input logic [15:0] loss_len);
    return ok ? loss_len : deb_len;
  endfunction

endpackage

// File: rtl/pll_lock_monitor_debounce.sv
// One lock channel: 2-flop synchronizer, asymmetric debounce counter and
// an error-driven force-clear of the qualified lock flag.
module lock_debounce
  import pll_lock_monitor_pkg::*;
#(
  parameter logic [15:0] DEB_LEN  = DEF_DEB_LEN,
  parameter logic [15:0] LOSS_LEN = DEF_LOSS_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_lock,
  input  logic force_clr,
  output logic lock_ok
);

  logic        meta_reg;
  logic        sync_reg;
  logic        force_seen_reg;
  logic        ok_reg;
  logic        ok_next;
  logic [15:0] cnt_reg;
  logic [15:0] cnt_next;
  logic [15:0] cnt_inc;
  logic [15:0] limit;
  logic        eff_lock;

  // A synchronized error also masks the lock, so the channel reads as unlocked.
  assign eff_lock = sync_reg & ~force_clr;
  assign cnt_inc  = cnt_reg + 16'd1;
  assign limit    = run_limit(ok_reg, DEB_LEN, LOSS_LEN);

  always_comb begin
    ok_next  = ok_reg;
    cnt_next = 16'd0;
    if (force_seen_reg) begin
      ok_next = 1'b0;
    end else if (eff_lock != ok_reg) begin
      if (cnt_inc == limit) begin
        ok_next = eff_lock;
      end else begin
        cnt_next = cnt_inc;
      end
    end
  end

  // The force-clear acts one edge after the synchronized error is first seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg       <= 1'b0;
      sync_reg       <= 1'b0;
      force_seen_reg <= 1'b0;
      ok_reg         <= 1'b0;
      cnt_reg        <= 16'd0;
    end else begin
      meta_reg       <= raw_lock;
      sync_reg       <= meta_reg;
      force_seen_reg <= force_clr;
      ok_reg         <= ok_next;
      cnt_reg        <= cnt_next;
    end
  end

  assign lock_ok = ok_reg;

endmodule

// File: rtl/pll_lock_monitor.sv
// Qualifies MMCM/QPLL lock for the POR sequencer, counts lock losses and
// issues a rate-limited relock request.
module pll_lock_monitor
  import pll_lock_monitor_pkg::*;
#(
  parameter logic [15:0] DEB_LEN  = DEF_DEB_LEN,
  parameter logic [15:0] LOSS_LEN = DEF_LOSS_LEN,
  parameter logic [19:0] HOLDOFF  = DEF_HOLDOFF,
  parameter int          CNT_W    = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             EOS,
  input  logic             MMCM_LOCK,
  input  logic             QPLL_LOCK,
  input  logic             QPLL_ERROR,
  input  logic             CLR_CNT,
  output logic             MMCM_LOCK_OK,
  output logic             QPLL_LOCK_OK,
  output logic             ALL_LOCKED,
  output logic             RELOCK_REQ,
  output logic [CNT_W-1:0] MMCM_LOSS_CNT,
  output logic [CNT_W-1:0] QPLL_LOSS_CNT
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             err_meta_reg;
  logic             s_err;
  logic [1:0]       raw_vec;
  logic [1:0]       force_vec;
  logic [1:0]       ok_vec;
  logic [1:0]       ok_prev_reg;
  logic [1:0]       fall_vec;
  logic [CNT_W-1:0] loss_cnt_reg [2];
  logic             all_locked_reg;

  relock_state_t    state_reg;
  relock_state_t    state_next;
  logic [19:0]      hold_cnt_reg;
  logic [19:0]      hold_cnt_next;
  logic             relock_reg;
  logic             relock_next;

  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      err_meta_reg <= 1'b0;
      s_err        <= 1'b0;
    end else begin
      err_meta_reg <= QPLL_ERROR;
      s_err        <= err_meta_reg;
    end
  end

  // Channel 0 is the MMCM (never force-cleared), channel 1 the QPLL.
  assign raw_vec   = {QPLL_LOCK, MMCM_LOCK};
  assign force_vec = {s_err, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      lock_debounce #(
        .DEB_LEN (DEB_LEN),
        .LOSS_LEN(LOSS_LEN)
      ) u_deb (
        .clk      (CLK),
        .rst_n    (EOS),
        .raw_lock (raw_vec[gi]),
        .force_clr(force_vec[gi]),
        .lock_ok  (ok_vec[gi])
      );

      // A clear coincident with a loss still records that loss.
      always_ff @(posedge CLK or negedge EOS) begin
        if (!EOS) begin
          loss_cnt_reg[gi] <= '0;
        end else if (CLR_CNT) begin
          loss_cnt_reg[gi] <= fall_vec[gi] ? CNT_ONE : '0;
        end else if (fall_vec[gi] && (loss_cnt_reg[gi] != CNT_MAX)) begin
          loss_cnt_reg[gi] <= loss_cnt_reg[gi] + CNT_ONE;
        end
      end
    end
  endgenerate

  assign fall_vec = ok_prev_reg & ~ok_vec;

  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      ok_prev_reg    <= 2'b00;
      all_locked_reg <= 1'b0;
    end else begin
      ok_prev_reg    <= ok_vec;
      all_locked_reg <= &ok_vec;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    relock_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|fall_vec) begin
          relock_next   = 1'b1;
          state_next    = HOLD;
          hold_cnt_next = 20'd0;
        end
      end
      HOLD: begin
        // Falls seen on the exit edge are deliberately swallowed.
        if (hold_cnt_reg == (HOLDOFF - 20'd1)) begin
          state_next    = IDLE;
          hold_cnt_next = 20'd0;
        end else begin
          hold_cnt_next = hold_cnt_reg + 20'd1;
        end
      end
      default: begin
        state_next    = IDLE;
        hold_cnt_next = 20'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= 20'd0;
      relock_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      relock_reg   <= relock_next;
    end
  end

  assign MMCM_LOCK_OK  = ok_vec[0];
  assign QPLL_LOCK_OK  = ok_vec[1];
  assign ALL_LOCKED    = all_locked_reg;
  assign RELOCK_REQ    = relock_reg;
  assign MMCM_LOSS_CNT = loss_cnt_reg[0];
  assign QPLL_LOSS_CNT = loss_cnt_reg[1];

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor with a history-based reference model.
module tb_pll_lock_monitor;

  localparam logic [15:0] DEB      = 16'd10;
  localparam logic [15:0] LOSS     = 16'd4;
  localparam logic [19:0] HOLD_CYC = 20'd50;
  localparam int          CW       = 2;
  localparam int          CMAX     = (1 << CW) - 1;

  logic          clk        = 1'b0;
  logic          eos        = 1'b1;
  logic          mmcm_lock  = 1'b0;
  logic          qpll_lock  = 1'b0;
  logic          qpll_error = 1'b0;
  logic          clr_cnt    = 1'b0;
  logic          mmcm_ok;
  logic          qpll_ok;
  logic          all_locked;
  logic          relock_req;
  logic [CW-1:0] mmcm_cnt;
  logic [CW-1:0] qpll_cnt;

  always #5 clk = ~clk;

  pll_lock_monitor #(
    .DEB_LEN (DEB),
    .LOSS_LEN(LOSS),
    .HOLDOFF (HOLD_CYC),
    .CNT_W   (CW)
  ) dut (
    .CLK          (clk),
    .EOS          (eos),
    .MMCM_LOCK    (mmcm_lock),
    .QPLL_LOCK    (qpll_lock),
    .QPLL_ERROR   (qpll_error),
    .CLR_CNT      (clr_cnt),
    .MMCM_LOCK_OK (mmcm_ok),
    .QPLL_LOCK_OK (qpll_ok),
    .ALL_LOCKED   (all_locked),
    .RELOCK_REQ   (relock_req),
    .MMCM_LOSS_CNT(mmcm_cnt),
    .QPLL_LOSS_CNT(qpll_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Raw input values sampled at each rising edge since time zero.
  bit mm_raw [4096];
  bit qp_raw [4096];
  bit er_raw [4096];

  int g     = 0;
  int base  = 0;
  int cur_e = -1;
  bit need_base;
  bit m_ok, q_ok, fm_pend, fq_pend, have_pulse, exp_relock, exp_all;
  int last_pulse, last_chg_m, last_chg_q, mcnt, qcnt;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s e=%0d got=%0d expected=%0d", name, cur_e, act, expv);
    end
  endtask

  task automatic lit(string name, logic [31:0] act, logic [31:0] expv);
    chk(name, act, expv);
    $display("check %s e=%0d value=%0d want=%0d", name, cur_e, act, expv);
  endtask

  task automatic reset_model();
    m_ok = 0; q_ok = 0; fm_pend = 0; fq_pend = 0; have_pulse = 0;
    exp_relock = 0; exp_all = 0; mcnt = 0; qcnt = 0; need_base = 1;
  endtask

  // Lock level as the debounce logic sees it at edge i (two flops behind).
  function automatic bit eff_at(int ch, int i);
    if (i - 2 < base) return 1'b0;
    if (ch == 0) return mm_raw[i-2];
    return qp_raw[i-2] & ~er_raw[i-2];
  endfunction

  // Flag flips when the last len observed samples all disagree with it and
  // none of them precede its previous change.
  function automatic bit qualifies(int ch, bit ok, int lc);
    int len;
    len = ok ? int'(LOSS) : int'(DEB);
    if (g - len + 1 <= lc) return 1'b0;
    for (int i = g - len + 1; i <= g; i++)
      if (eff_at(ch, i) == ok) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit new_m, new_q;
    if (!eos) begin
      reset_model();
      return;
    end
    if (need_base) begin
      base = g; need_base = 0; last_chg_m = g - 1; last_chg_q = g - 1;
    end
    cur_e = g - base;
    mm_raw[g] = mmcm_lock; qp_raw[g] = qpll_lock; er_raw[g] = qpll_error;

    exp_relock = 0;
    if ((fm_pend || fq_pend) && (!have_pulse || (g - last_pulse) > int'(HOLD_CYC))) begin
      exp_relock = 1; have_pulse = 1; last_pulse = g;
    end
    if (clr_cnt) mcnt = fm_pend ? 1 : 0;
    else if (fm_pend && mcnt < CMAX) mcnt++;
    if (clr_cnt) qcnt = fq_pend ? 1 : 0;
    else if (fq_pend && qcnt < CMAX) qcnt++;
    exp_all = m_ok & q_ok;

    new_m = m_ok;
    if (qualifies(0, m_ok, last_chg_m)) begin new_m = ~m_ok; last_chg_m = g; end
    new_q = q_ok;
    if (g - 3 >= base && er_raw[g-3]) begin new_q = 0; last_chg_q = g; end
    else if (qualifies(1, q_ok, last_chg_q)) begin new_q = ~q_ok; last_chg_q = g; end
    fm_pend = m_ok & ~new_m;
    fq_pend = q_ok & ~new_q;
    m_ok = new_m;
    q_ok = new_q;
  endtask

  task automatic compare_all();
    chk("mmcm_ok", 32'(mmcm_ok), 32'(m_ok));
    chk("qpll_ok", 32'(qpll_ok), 32'(q_ok));
    chk("all_locked", 32'(all_locked), 32'(exp_all));
    chk("relock_req", 32'(relock_req), 32'(exp_relock));
    chk("mmcm_cnt", 32'(mmcm_cnt), 32'(mcnt));
    chk("qpll_cnt", 32'(qpll_cnt), 32'(qcnt));
  endtask

  task automatic tick();
    @(posedge clk);
    g++;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic to_edge(int k);
    int guard;
    guard = 0;
    while (cur_e < k && guard < 2000) begin
      tick();
      guard++;
    end
    checks++;
    if (cur_e < k) begin
      failures++;
      $display("FAIL to_edge got=%0d expected=%0d", cur_e, k);
    end
  endtask

  task automatic lit_all_zero(string tag);
    lit({tag, "_mmcm_ok"}, 32'(mmcm_ok), 0);
    lit({tag, "_qpll_ok"}, 32'(qpll_ok), 0);
    lit({tag, "_all"}, 32'(all_locked), 0);
    lit({tag, "_relock"}, 32'(relock_req), 0);
    lit({tag, "_mcnt"}, 32'(mmcm_cnt), 0);
    lit({tag, "_qcnt"}, 32'(qpll_cnt), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_model();
    #1 eos = 1'b0;
    repeat (3) tick();
    lit_all_zero("reset");

    // Acquire: both locks sampled high from edge 0.
    eos = 1'b1; mmcm_lock = 1'b1; qpll_lock = 1'b1; cur_e = -1;
    to_edge(10); lit("acq_m_pre", 32'(mmcm_ok), 0); lit("acq_q_pre", 32'(qpll_ok), 0);
    to_edge(11); lit("acq_m", 32'(mmcm_ok), 1); lit("acq_q", 32'(qpll_ok), 1);
    lit("acq_all_pre", 32'(all_locked), 0);
    to_edge(12); lit("acq_all", 32'(all_locked), 1); lit("acq_relock", 32'(relock_req), 0);

    // Glitch shorter than the loss threshold, then one that is long enough.
    to_edge(19); mmcm_lock = 1'b0; to_edge(22); mmcm_lock = 1'b1;
    to_edge(35); lit("glitch3_ok", 32'(mmcm_ok), 1);
    to_edge(39); mmcm_lock = 1'b0; to_edge(43); mmcm_lock = 1'b1;
    to_edge(44); lit("loss_ok_pre", 32'(mmcm_ok), 1);
    to_edge(45); lit("loss_ok", 32'(mmcm_ok), 0);
    to_edge(46); lit("loss_relock", 32'(relock_req), 1); lit("loss_mcnt", 32'(mmcm_cnt), 1);
    to_edge(47); lit("loss_relock_end", 32'(relock_req), 0);

    // Single-cycle QPLL error while locked.
    to_edge(99); qpll_error = 1'b1; to_edge(100); qpll_error = 1'b0;
    to_edge(102); lit("err_ok_pre", 32'(qpll_ok), 1);
    to_edge(103); lit("err_ok", 32'(qpll_ok), 0);
    to_edge(104); lit("err_relock", 32'(relock_req), 1); lit("err_qcnt", 32'(qpll_cnt), 1);
    to_edge(112); lit("err_relock_pre", 32'(qpll_ok), 0);
    to_edge(113); lit("err_relocked", 32'(qpll_ok), 1);

    to_edge(149); clr_cnt = 1'b1; to_edge(150); clr_cnt = 1'b0;
    lit("clr_mcnt", 32'(mmcm_cnt), 0); lit("clr_qcnt", 32'(qpll_cnt), 0);

    // Holdoff: three losses 20 cycles apart, then one 60 after the first.
    for (int k = 160; k <= 200; k += 20) begin
      to_edge(k - 1); mmcm_lock = 1'b0; to_edge(k + 3); mmcm_lock = 1'b1;
      to_edge(k + 6); lit("hold_relock", 32'(relock_req), (k == 160) ? 1 : 0);
    end
    lit("hold_mcnt", 32'(mmcm_cnt), 3);
    to_edge(219); mmcm_lock = 1'b0; to_edge(223); mmcm_lock = 1'b1;
    to_edge(226); lit("hold_second", 32'(relock_req), 1);
    // Fall registered on the same edge the holdoff expires.
    to_edge(269); mmcm_lock = 1'b0; to_edge(273); mmcm_lock = 1'b1;
    to_edge(276); lit("hold_exit_fall", 32'(relock_req), 0);

    // Saturation with repeated QPLL error losses.
    for (int k = 300; k <= 380; k += 20) begin
      to_edge(k - 1); qpll_error = 1'b1; to_edge(k); qpll_error = 1'b0;
      to_edge(k + 4); lit("sat_relock", 32'(relock_req), (k == 300 || k == 360) ? 1 : 0);
    end
    lit("sat_qcnt", 32'(qpll_cnt), 3);
    to_edge(399); qpll_error = 1'b1; to_edge(400); qpll_error = 1'b0;
    to_edge(403); clr_cnt = 1'b1; to_edge(404); clr_cnt = 1'b0;
    lit("clr_fall_qcnt", 32'(qpll_cnt), 1);
    to_edge(419); clr_cnt = 1'b1; to_edge(420); clr_cnt = 1'b0;
    lit("clr_alone_qcnt", 32'(qpll_cnt), 0);

    // Reset during HOLD, then a fresh loss must pulse immediately.
    to_edge(424); mmcm_lock = 1'b0; to_edge(428); mmcm_lock = 1'b1;
    to_edge(431); lit("pre_rst_relock", 32'(relock_req), 1);
    to_edge(440);
    eos = 1'b0;
    #1;
    lit_all_zero("midrst");
    reset_model();
    repeat (3) tick();
    eos = 1'b1; cur_e = -1;
    to_edge(11); lit("reacq_m", 32'(mmcm_ok), 1); lit("reacq_q", 32'(qpll_ok), 1);
    to_edge(19); mmcm_lock = 1'b0; to_edge(23); mmcm_lock = 1'b1;
    to_edge(26); lit("fresh_relock", 32'(relock_req), 1); lit("fresh_mcnt", 32'(mmcm_cnt), 1);
    to_edge(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
